// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRmwRd,
        StRmwWr
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/dmem_byte_merge.sv
// Per-byte merge of store data into an existing word, selected by byte enables.
module dmem_byte_merge (
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU priority with DMA starvation guard,
// one-cycle read sequencing and read-modify-write for partial stores.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [3:0]        dma_be,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,

    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [31:0]       cpu_rdata_q, dma_rdata_q;

    logic              dma_win, cpu_win, any_win;
    logic              sel_we;
    logic [3:0]        sel_be;
    logic [ADDR_W-3:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       merged;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], cpu_addr[1:0],
                                dma_addr[31:ADDR_W], dma_addr[1:0]};

    // Arbitration only ever resolves in idle; other states grant nobody.
    assign dma_win = (state_q == StIdle) && dma_req &&
                     ((starve_cnt_q == CntW'(STARVE_MAX)) || !cpu_req);
    assign cpu_win = (state_q == StIdle) && cpu_req && !dma_win;
    assign any_win = cpu_win || dma_win;

    assign sel_we    = dma_win ? dma_we    : cpu_we;
    assign sel_be    = dma_win ? dma_be    : cpu_be;
    assign sel_addr  = dma_win ? dma_addr[ADDR_W-1:2] : cpu_addr[ADDR_W-1:2];
    assign sel_wdata = dma_win ? dma_wdata : cpu_wdata;

    dmem_byte_merge u_merge (
        .old_data (ram_rdata),
        .new_data (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= OWN_CPU;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            starve_cnt_q <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_rdata_q  <= cpu_rdata;
            dma_rdata_q  <= dma_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;

        if (!dma_req || dma_win) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CntW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        unique case (state_q)
            StIdle: begin
                if (any_win) begin
                    owner_d = dma_win ? OWN_DMA : OWN_CPU;
                    addr_d  = sel_addr;
                    be_d    = sel_be;
                    wdata_d = sel_wdata;
                    if (!sel_we) begin
                        state_d = StRdWait;
                    end else if (sel_be != BE_FULL && sel_be != BE_NONE) begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRdWait: state_d = StIdle;
            StRmwRd:  state_d = StRmwWr;
            StRmwWr:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_gnt    = cpu_win;
        dma_gnt    = dma_win;
        cpu_rvalid = 1'b0;
        dma_rvalid = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (any_win) begin
                    ram_addr = sel_addr;
                    if (sel_we && sel_be == BE_FULL) begin
                        ram_we    = 1'b1;
                        ram_wdata = sel_wdata;
                    end
                end
            end
            StRdWait: begin
                cpu_rvalid = (owner_q == OWN_CPU);
                dma_rvalid = (owner_q == OWN_DMA);
            end
            StRmwRd: begin
                // Re-present the address so ram_rdata stays valid into the write cycle.
            end
            StRmwWr: begin
                ram_we    = 1'b1;
                ram_wdata = merged;
            end
            default: begin
            end
        endcase

        cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
        dma_rdata = dma_rvalid ? ram_rdata : dma_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read RAM model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [3:0]  dma_be;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [0:16383];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    dmem_arbiter #(.ADDR_W(16), .STARVE_MAX(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_be     (dma_be),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        dma_req = req; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = wdata;
    endtask

    initial begin
        reset_n = 1'b0;
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        set_dma(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rst_state", 32'(dut.state_q), 32'(StIdle));
        chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Preload through the arbiter: CPU word 0x20, DMA word 0x40.
        @(negedge clock);
        set_cpu(1, 1, 4'hF, 32'h20, 32'h11223344);
        #1;
        chk("pre_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("pre_cpu_we", 32'(ram_we), 32'd1);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        set_dma(1, 1, 4'hF, 32'h40, 32'hCAFEF00D);
        #1;
        chk("pre_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("pre_dma_we", 32'(ram_we), 32'd1);
        chk("pre_dma_addr", 32'(ram_addr), 32'd16);

        // Full write then read of 0x10.
        @(negedge clock);
        set_dma(0, 0, 4'h0, 32'h0, 32'h0);
        set_cpu(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        #1;
        chk("fw_gnt", 32'(cpu_gnt), 32'd1);
        chk("fw_we", 32'(ram_we), 32'd1);
        chk("fw_addr", 32'(ram_addr), 32'd4);
        chk("fw_wdata", ram_wdata, 32'hDEADBEEF);
        @(negedge clock);
        set_cpu(1, 0, 4'h0, 32'h10, 32'h0);
        #1;
        chk("rd_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("fw_no_rvalid", 32'(cpu_rvalid), 32'd0);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);

        // Partial write byte 1 of word 0x20, with DMA waiting during the RMW.
        @(negedge clock);
        set_cpu(1, 1, 4'b0010, 32'h20, 32'h0000AA00);
        #1;
        chk("pw_gnt", 32'(cpu_gnt), 32'd1);
        chk("pw_we0", 32'(ram_we), 32'd0);
        chk("pw_addr", 32'(ram_addr), 32'd8);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        set_dma(1, 0, 4'h0, 32'h40, 32'h0);
        #1;
        chk("pw_state_rd", 32'(dut.state_q), 32'(StRmwRd));
        chk("pw_we1", 32'(ram_we), 32'd0);
        chk("pw_dma_gnt1", 32'(dma_gnt), 32'd0);
        @(negedge clock);
        #1;
        chk("pw_state_wr", 32'(dut.state_q), 32'(StRmwWr));
        chk("pw_we2", 32'(ram_we), 32'd1);
        chk("pw_wdata", ram_wdata, 32'h1122AA44);
        chk("pw_addr2", 32'(ram_addr), 32'd8);
        chk("pw_dma_gnt2", 32'(dma_gnt), 32'd0);
        @(negedge clock);
        #1;
        chk("dr_gnt", 32'(dma_gnt), 32'd1);
        chk("dr_addr", 32'(ram_addr), 32'd16);
        @(negedge clock);
        set_dma(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("dr_rvalid", 32'(dma_rvalid), 32'd1);
        chk("dr_rdata", dma_rdata, 32'hCAFEF00D);
        chk("dr_cpu_hold", cpu_rdata, 32'hDEADBEEF);
        chk("dr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        @(negedge clock);
        set_cpu(1, 0, 4'h0, 32'h20, 32'h0);
        #1;
        chk("pr_gnt", 32'(cpu_gnt), 32'd1);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("pr_rdata", cpu_rdata, 32'h1122AA44);

        // Starvation: CPU streams full writes while DMA waits.
        @(negedge clock);
        set_cpu(1, 1, 4'hF, 32'h100, 32'h0);
        set_dma(1, 0, 4'h0, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            cpu_wdata = 32'(k);
            #1;
            chk($sformatf("sv_cpu_gnt%0d", k), 32'(cpu_gnt), 32'd1);
            chk($sformatf("sv_dma_gnt%0d", k), 32'(dma_gnt), 32'd0);
        end
        @(negedge clock);
        #1;
        chk("sv_dma_win", 32'(dma_gnt), 32'd1);
        chk("sv_cpu_lose", 32'(cpu_gnt), 32'd0);
        chk("sv_ram_we", 32'(ram_we), 32'd0);
        @(negedge clock);
        set_dma(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("sv_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
        chk("sv_dma_rdata", dma_rdata, 32'hCAFEF00D);
        chk("sv_rdwait_nognt", 32'(cpu_gnt), 32'd0);
        chk("sv_mem", mem[64], 32'd3);
        @(negedge clock);
        #1;
        chk("sv_cpu_again", 32'(cpu_gnt), 32'd1);

        // Simultaneous reads: CPU first, DMA right after cpu_rvalid.
        @(negedge clock);
        set_cpu(1, 0, 4'h0, 32'h10, 32'h0);
        set_dma(1, 0, 4'h0, 32'h20, 32'h0);
        #1;
        chk("sim_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("sim_dma_gnt0", 32'(dma_gnt), 32'd0);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("sim_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("sim_dma_gnt1", 32'(dma_gnt), 32'd0);
        @(negedge clock);
        #1;
        chk("sim_dma_gnt2", 32'(dma_gnt), 32'd1);
        @(negedge clock);
        set_dma(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("sim_dma_rvalid", 32'(dma_rvalid), 32'd1);
        chk("sim_dma_rdata", dma_rdata, 32'h1122AA44);

        // Reset in the middle of an RMW.
        @(negedge clock);
        set_cpu(1, 1, 4'b0001, 32'h10, 32'h000000FF);
        #1;
        chk("rr_gnt", 32'(cpu_gnt), 32'd1);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rr_state", 32'(dut.state_q), 32'(StRmwRd));
        reset_n = 1'b0;
        #1;
        chk("rr_state_idle", 32'(dut.state_q), 32'(StIdle));
        chk("rr_we", 32'(ram_we), 32'd0);
        chk("rr_rdata", cpu_rdata, 32'h0);
        @(negedge clock);
        #1;
        chk("rr_we2", 32'(ram_we), 32'd0);
        chk("rr_mem", mem[4], 32'hDEADBEEF);
        reset_n = 1'b1;

        // Address wrap and null write.
        @(negedge clock);
        set_cpu(1, 0, 4'h0, 32'h0001_0020, 32'h0);
        #1;
        chk("wr_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'd8);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("wr_rdata", cpu_rdata, 32'h1122AA44);
        @(negedge clock);
        set_cpu(1, 1, 4'h0, 32'h10, 32'h12345678);
        #1;
        chk("nw_gnt", 32'(cpu_gnt), 32'd1);
        chk("nw_we", 32'(ram_we), 32'd0);
        @(negedge clock);
        set_cpu(0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("nw_state", 32'(dut.state_q), 32'(StIdle));
        chk("nw_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("nw_mem", mem[4], 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 64 KB data RAM between the CPU memory stage and a DMA/loader requester. The RAM is word-wide with one write-enable.
- Arbitrates between the two requesters with CPU priority and a starvation guard.
- Sequences reads, which have one cycle of RAM latency.
- Turns partial-word stores (sb/sh) into read-modify-write pairs.
- Sits between the CPU/DMA and the data RAM instance.

Parameters:
- ADDR_W, 16: byte-address bits decoded. Word index is addr[ADDR_W-1:2]; higher bits are ignored, so addresses wrap.
- STARVE_MAX, 4: number of consecutive cycles DMA may be blocked by CPU grants before DMA wins arbitration.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request. Hold it, with we/be/addr/wdata, stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_be  in  4  byte enables for writes; bit i enables byte [8i+7:8i]. Ignored on reads.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  write data, already lane-aligned.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_rvalid  out  1  read data valid.
- cpu_rdata  out  32  read data.
- dma_req, dma_we, dma_be, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* set, for the DMA requester.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W-2  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after ram_addr is sampled.

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE, starve_cnt = 0, owner = CPU.
  - All gnt, rvalid and ram_we outputs are 0; rdata outputs are 0.
  - Reset mid-RMW abandons the operation and issues no RAM write.
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR.
- Arbitration happens only in IDLE:
  - The winner is DMA if dma_req and (starve_cnt == STARVE_MAX or !cpu_req); otherwise CPU if cpu_req.
  - gnt is combinational and asserted in the acceptance cycle for the winner only.
  - ram_addr is driven from the winner's address in that same cycle.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) in each cycle where dma_req = 1 and dma_gnt = 0.
  - It clears on dma_gnt or when dma_req = 0.
- Read (we = 0):
  - Accept, then go to RD_WAIT.
  - In RD_WAIT, <owner>_rvalid = 1 for one cycle and <owner>_rdata = ram_rdata; the other requester's rdata holds its last value. Then return to IDLE.
  - Latency: 1 cycle from gnt to rvalid. Throughput: 1 read per 2 cycles.
  - No request is accepted in RD_WAIT.
- Full write (we = 1, be = 4'b1111): ram_we = 1 and ram_wdata = wdata in the acceptance cycle. State stays IDLE, so back-to-back full writes run at 1 per cycle.
- Null write (we = 1, be = 4'b0000): accepted with gnt, no RAM access, stay in IDLE.
- Partial write (any other be):
  - On accept, latch addr/be/wdata/owner, drive the read address, and go to RMW_RD.
  - RMW_RD: wait for ram_rdata, then go to RMW_WR.
  - RMW_WR: ram_we = 1 with ram_wdata = merge(ram_rdata, latched wdata, latched be), ram_addr = latched address, then return to IDLE.
  - RMW_RD is required because ram_rdata is only valid in the cycle after the address.
  - Occupancy is 3 cycles; no grants are issued in RMW_RD or RMW_WR.
- Simultaneous requests: CPU wins unless the starvation condition holds. The loser sees gnt = 0 and must hold its request.
- ram_we is 0 in every state and cycle not named above.
- No rvalid is ever produced for writes.

Decomposition:
- Shared package dmem_pkg contains:
  - the state enum (IDLE, RD_WAIT, RMW_RD, RMW_WR);
  - the owner encoding (OWN_CPU = 0, OWN_DMA = 1);
  - the constants BE_FULL = 4'b1111 and BE_NONE = 4'b0000.
- One combinational sub-module, dmem_byte_merge:
  - inputs old[31:0], new[31:0], be[3:0];
  - output per-byte select of new where be is set.
  - Reused by the verification model.

Test Plan:
- CPU full write addr 0x0000_0010 data 0xDEADBEEF, then read the same address → ram_we pulse with ram_addr = 4; read gnt, next cycle cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF.
- Word 0x20 holds 0x11223344; CPU write be = 4'b0010, wdata = 0x0000AA00 → RMW_RD then RMW_WR; ram_wdata = 0x1122AA44; a following read returns 0x1122AA44.
- cpu_req held high with back-to-back full writes and dma_req high → dma_gnt asserts after exactly STARVE_MAX (4) blocked cycles; starve_cnt = 0 afterwards.
- cpu_req and dma_req both rise in the same IDLE cycle, both reads, starve_cnt = 0 → CPU granted first; DMA granted in the cycle after cpu_rvalid; dma_rvalid delivers the DMA word.
- Deassert reset_n during RMW_RD of a be = 4'b0001 write → no ram_we; state IDLE, all gnt/rvalid 0; RAM word unchanged.
- Address 0x0001_0020 with ADDR_W = 16 → ram_addr = 8 (wrap); be = 4'b0000 write → gnt, no ram_we.
